// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: default widths, ALU-op width and the ID/EX stage-entry record.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 32;
  localparam int unsigned CPU_REG_AW = 5;
  localparam int unsigned ALUOP_W    = 4;

  // Payload held in the ID/EX register: operands, immediate, controls and source indices.
  typedef struct packed {
    logic [CPU_DATA_W-1:0] data1;
    logic [CPU_DATA_W-1:0] data2;
    logic [CPU_DATA_W-1:0] imm;
    logic [CPU_REG_AW-1:0] write_reg;
    logic                  reg_write;
    logic                  mem_read;
    logic [ALUOP_W-1:0]    alu_op;
    logic [CPU_REG_AW-1:0] src1;
    logic [CPU_REG_AW-1:0] src2;
  } stage_entry_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode -> ID/EX -> EX bundle: input handshake, decoded fields, writeback port and output handshake.
interface id_ex_stage_if
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned REG_AW = CPU_REG_AW
);

  logic              InValid;
  logic              InReady;
  logic [REG_AW-1:0] ReadReg1;
  logic [REG_AW-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [REG_AW-1:0] InWriteReg;
  logic              InRegWrite;
  logic              InMemRead;
  logic [DATA_W-1:0] InImm;
  logic [ALUOP_W-1:0] InALUOp;

  logic              WbRegWrite;
  logic [REG_AW-1:0] WbWriteReg;
  logic [DATA_W-1:0] WbWriteData;

  logic              Flush;

  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutData1;
  logic [DATA_W-1:0] OutData2;
  logic [DATA_W-1:0] OutImm;
  logic [REG_AW-1:0] OutWriteReg;
  logic              OutRegWrite;
  logic              OutMemRead;
  logic [ALUOP_W-1:0] OutALUOp;

  // Upstream/downstream environment side
  modport master (
    output InValid, ReadReg1, ReadReg2, ReadData1, ReadData2,
           InWriteReg, InRegWrite, InMemRead, InImm, InALUOp,
           WbRegWrite, WbWriteReg, WbWriteData, Flush, OutReady,
    input  InReady, OutValid, OutData1, OutData2, OutImm,
           OutWriteReg, OutRegWrite, OutMemRead, OutALUOp
  );

  // Pipeline stage side
  modport slave (
    input  InValid, ReadReg1, ReadReg2, ReadData1, ReadData2,
           InWriteReg, InRegWrite, InMemRead, InImm, InALUOp,
           WbRegWrite, WbWriteReg, WbWriteData, Flush, OutReady,
    output InReady, OutValid, OutData1, OutData2, OutImm,
           OutWriteReg, OutRegWrite, OutMemRead, OutALUOp
  );

endinterface

// File: rtl/id_ex_bypass.sv
// Per-operand source select: register 0 reads as zero; with ID_EX_WB_BYPASS_EN a same-cycle
// writeback to the source register overrides the supplied data.
module id_ex_bypass
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned REG_AW = CPU_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] src_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand_c
);

`ifdef ID_EX_WB_BYPASS_EN
  logic wb_hit_c;

  assign wb_hit_c = wb_we && (wb_reg != '0) && (wb_reg == src);

  always_comb begin
    operand_c = src_data;
    if (wb_hit_c) operand_c = wb_data;
    if (src == '0) operand_c = '0;
  end
`else
  logic unused_wb;

  assign unused_wb = ^{wb_we, wb_reg, wb_data};

  always_comb begin
    operand_c = src_data;
    if (src == '0) operand_c = '0;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, load-use stall and optional writeback
// bypass/refresh of held operands (enabled by defining ID_EX_WB_BYPASS_EN).
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = CPU_DATA_W,
  parameter int unsigned REG_AW     = CPU_REG_AW,
  parameter int unsigned LOAD_STALL = 1
) (
  input logic          clock,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  localparam int unsigned STALL_W = 2;

  stage_entry_t       held_q;
  stage_entry_t       held_d;
  logic               valid_q;
  logic               valid_d;
  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;

  logic               hazard_c;
  logic               ready_c;
  logic               accept_c;
  logic [REG_AW-1:0]  sel_reg1_c;
  logic [REG_AW-1:0]  sel_reg2_c;
  logic [DATA_W-1:0]  sel_data1_c;
  logic [DATA_W-1:0]  sel_data2_c;
  logic [DATA_W-1:0]  op1_c;
  logic [DATA_W-1:0]  op2_c;

  // Load-use: the held load's destination is a source of the incoming instruction.
  assign hazard_c = valid_q && held_q.mem_read && (held_q.write_reg != '0) && bus.InValid &&
                    ((held_q.write_reg == bus.ReadReg1) || (held_q.write_reg == bus.ReadReg2));

  assign ready_c  = (!valid_q || bus.OutReady) && !hazard_c && (stall_q == '0);
  assign accept_c = bus.InValid && ready_c;

`ifdef ID_EX_WB_BYPASS_EN
  // Selectors serve the incoming instruction on accept, otherwise refresh the held one.
  assign sel_reg1_c  = accept_c ? bus.ReadReg1  : held_q.src1;
  assign sel_reg2_c  = accept_c ? bus.ReadReg2  : held_q.src2;
  assign sel_data1_c = accept_c ? bus.ReadData1 : held_q.data1;
  assign sel_data2_c = accept_c ? bus.ReadData2 : held_q.data2;
`else
  logic unused_src;

  assign unused_src  = ^{held_q.src1, held_q.src2};
  assign sel_reg1_c  = bus.ReadReg1;
  assign sel_reg2_c  = bus.ReadReg2;
  assign sel_data1_c = bus.ReadData1;
  assign sel_data2_c = bus.ReadData2;
`endif

  id_ex_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass1 (
    .src       (sel_reg1_c),
    .src_data  (sel_data1_c),
    .wb_we     (bus.WbRegWrite),
    .wb_reg    (bus.WbWriteReg),
    .wb_data   (bus.WbWriteData),
    .operand_c (op1_c)
  );

  id_ex_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass2 (
    .src       (sel_reg2_c),
    .src_data  (sel_data2_c),
    .wb_we     (bus.WbRegWrite),
    .wb_reg    (bus.WbWriteReg),
    .wb_data   (bus.WbWriteData),
    .operand_c (op2_c)
  );

  // Next-state: flush beats stall and accept; accept beats drain; held data otherwise kept.
  always_comb begin
    valid_d = valid_q;
    held_d  = held_q;
    stall_d = stall_q;
    if (bus.Flush) begin
      valid_d = 1'b0;
      stall_d = '0;
    end else begin
      if (stall_q != '0) stall_d = stall_q - STALL_W'(1);
      if (hazard_c && bus.OutReady) stall_d = STALL_W'(LOAD_STALL - 1);
      if (accept_c) begin
        valid_d          = 1'b1;
        held_d.data1     = op1_c;
        held_d.data2     = op2_c;
        held_d.imm       = bus.InImm;
        held_d.write_reg = bus.InWriteReg;
        held_d.reg_write = bus.InRegWrite;
        held_d.mem_read  = bus.InMemRead;
        held_d.alu_op    = bus.InALUOp;
`ifdef ID_EX_WB_BYPASS_EN
        held_d.src1      = bus.ReadReg1;
        held_d.src2      = bus.ReadReg2;
`endif
      end else if (valid_q && bus.OutReady) begin
        valid_d = 1'b0;
`ifdef ID_EX_WB_BYPASS_EN
      end else if (valid_q) begin
        held_d.data1 = op1_c;
        held_d.data2 = op2_c;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      held_q  <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      held_q  <= held_d;
      stall_q <= stall_d;
    end
  end

  assign bus.InReady     = ready_c;
  assign bus.OutValid    = valid_q;
  assign bus.OutData1    = held_q.data1;
  assign bus.OutData2    = held_q.data2;
  assign bus.OutImm      = held_q.imm;
  assign bus.OutWriteReg = held_q.write_reg;
  assign bus.OutRegWrite = held_q.reg_write;
  assign bus.OutMemRead  = held_q.mem_read;
  assign bus.OutALUOp    = held_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, directed hazard/refresh/flush/reset sequences and a
// randomized run against a transaction-level reference model. Honours ID_EX_WB_BYPASS_EN.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned LS = 2;
`ifdef ID_EX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .LOAD_STALL(LS)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic ir_seen;

  // Reference model: the single instruction slot and the stall counter.
  bit          m_valid;
  int          m_stall;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [4:0]  m_wr, m_s1, m_s2;
  bit          m_rw, m_mr;
  logic [3:0]  m_alu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] r, input logic [31:0] d);
    if (r == 5'd0) return 32'd0;
    if (BYP && bus.WbRegWrite && bus.WbWriteReg != 5'd0 && bus.WbWriteReg == r)
      return bus.WbWriteData;
    return d;
  endfunction

  function automatic bit m_hazard();
    return m_valid && m_mr && (m_wr != 5'd0) && bus.InValid &&
           (m_wr == bus.ReadReg1 || m_wr == bus.ReadReg2);
  endfunction

  function automatic bit m_ready();
    return (!m_valid || bus.OutReady) && !m_hazard() && (m_stall == 0);
  endfunction

  task automatic model_step();
    bit acc;
    bit haz;
    acc = bus.InValid && m_ready();
    haz = m_hazard();
    if (rst) begin
      m_valid = 0; m_stall = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
      m_wr = 0; m_s1 = 0; m_s2 = 0; m_rw = 0; m_mr = 0; m_alu = 0;
    end else if (bus.Flush) begin
      m_valid = 0;
      m_stall = 0;
    end else begin
      if (m_stall > 0) m_stall--;
      if (haz && bus.OutReady) m_stall = LS - 1;
      if (acc) begin
        m_valid = 1;
        m_d1 = opnd(bus.ReadReg1, bus.ReadData1);
        m_d2 = opnd(bus.ReadReg2, bus.ReadData2);
        m_imm = bus.InImm; m_wr = bus.InWriteReg; m_rw = bus.InRegWrite;
        m_mr = bus.InMemRead; m_alu = bus.InALUOp;
        m_s1 = bus.ReadReg1; m_s2 = bus.ReadReg2;
      end else if (m_valid && bus.OutReady) begin
        m_valid = 0;
      end else if (m_valid && BYP) begin
        m_d1 = opnd(m_s1, m_d1);
        m_d2 = opnd(m_s2, m_d2);
      end
    end
  endtask

  // One clock: check InReady before the edge, advance model, check registered outputs after.
  task automatic cycle();
    #1;
    ir_seen = bus.InReady;
    chk("in_ready", 64'(ir_seen), 64'(m_ready()));
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid",     64'(bus.OutValid),    64'(m_valid));
    chk("out_data1",     64'(bus.OutData1),    64'(m_d1));
    chk("out_data2",     64'(bus.OutData2),    64'(m_d2));
    chk("out_imm",       64'(bus.OutImm),      64'(m_imm));
    chk("out_write_reg", 64'(bus.OutWriteReg), 64'(m_wr));
    chk("out_reg_write", 64'(bus.OutRegWrite), 64'(m_rw));
    chk("out_mem_read",  64'(bus.OutMemRead),  64'(m_mr));
    chk("out_alu_op",    64'(bus.OutALUOp),    64'(m_alu));
  endtask

  task automatic drive(input bit iv, input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2, input bit we,
                       input logic [4:0] wr, input logic [31:0] wd, input bit ordy);
    bus.InValid = iv; bus.ReadReg1 = r1; bus.ReadData1 = d1;
    bus.ReadReg2 = r2; bus.ReadData2 = d2;
    bus.WbRegWrite = we; bus.WbWriteReg = wr; bus.WbWriteData = wd;
    bus.OutReady = ordy;
  endtask

  task automatic set_ctl(input logic [4:0] wr, input bit rw, input bit mr);
    bus.InWriteReg = wr; bus.InRegWrite = rw; bus.InMemRead = mr;
    bus.InImm = 32'h0000_0100 + 32'(wr); bus.InALUOp = 4'(wr);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.Flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    bit iv; logic [4:0] r1; logic [31:0] d1; logic [4:0] r2; logic [31:0] d2;
    bit we; logic [4:0] wr; logic [31:0] wd;
    bit ev; logic [31:0] e1_on, e2_on, e1_off, e2_off;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{1'b1, 5'd3, 32'h11,  5'd4, 32'h22,  1'b0, 5'd0, 32'h0,   1'b1, 32'h11,  32'h22,  32'h11,  32'h22};
    vt[1] = '{1'b1, 5'd1, 32'hAB,  5'd5, 32'hAA,  1'b1, 5'd5, 32'h55,  1'b1, 32'hAB,  32'h55,  32'hAB,  32'hAA};
    vt[2] = '{1'b1, 5'd0, 32'hFF,  5'd0, 32'hEE,  1'b1, 5'd0, 32'h77,  1'b1, 32'h0,   32'h0,   32'h0,   32'h0};
    vt[3] = '{1'b0, 5'd8, 32'h1,   5'd8, 32'h2,   1'b1, 5'd8, 32'h3,   1'b0, 32'h0,   32'h0,   32'h0,   32'h0};
    vt[4] = '{1'b1, 5'd9, 32'h123, 5'd9, 32'h456, 1'b1, 5'd9, 32'h789, 1'b1, 32'h789, 32'h789, 32'h123, 32'h456};
    vt[5] = '{1'b1, 5'd2, 32'hDEAD,5'd6, 32'hBEEF,1'b1, 5'd7, 32'h1,   1'b1, 32'hDEAD,32'hBEEF,32'hDEAD,32'hBEEF};

    rst = 1'b1;
    bus.Flush = 1'b0;
    set_ctl(5'd0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.OutValid), 64'd0);
    chk("rst_data1", 64'(bus.OutData1), 64'd0);
    chk("rst_data2", 64'(bus.OutData2), 64'd0);
    chk("rst_imm",   64'(bus.OutImm),   64'd0);
    chk("rst_wreg",  64'(bus.OutWriteReg), 64'd0);
    chk("rst_ready", 64'(bus.InReady),  64'd1);

    // Vector table: single-cycle accepts with the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      set_ctl(5'(i + 10), 1'b1, 1'b0);
      drive(vt[i].iv, vt[i].r1, vt[i].d1, vt[i].r2, vt[i].d2, vt[i].we, vt[i].wr, vt[i].wd, 1'b1);
      cycle();
      chk("tbl_valid", 64'(bus.OutValid), 64'(vt[i].ev));
      chk("tbl_data1", 64'(bus.OutData1), 64'(BYP ? vt[i].e1_on : vt[i].e1_off));
      chk("tbl_data2", 64'(bus.OutData2), 64'(BYP ? vt[i].e2_on : vt[i].e2_off));
    end

    // Load-use hazard with a two-cycle stall.
    reset_dut();
    set_ctl(5'd7, 1'b1, 1'b1);
    drive(1'b1, 5'd1, 32'h5, 5'd2, 32'h6, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle();
    chk("load_held", 64'(bus.OutMemRead), 64'd1);
    set_ctl(5'd3, 1'b1, 1'b0);
    drive(1'b1, 5'd7, 32'h70, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle();
    chk("haz_ready0",   64'(ir_seen),      64'd0);
    chk("haz_bubble",   64'(bus.OutValid), 64'd0);
    cycle();
    chk("stall_ready0", 64'(ir_seen),      64'd0);
    chk("stall_bubble", 64'(bus.OutValid), 64'd0);
    cycle();
    chk("stall_done_ready", 64'(ir_seen),      64'd1);
    chk("post_stall_valid", 64'(bus.OutValid), 64'd1);
    chk("post_stall_data1", 64'(bus.OutData1), 64'h70);

    // Held-operand refresh, seamless handoff and register-0 rule.
    reset_dut();
    drive(1'b1, 5'd4, 32'h10, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle();
    chk("hold_data1", 64'(bus.OutData1), 64'h10);
    drive(1'b0, 5'd4, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h99, 1'b0);
    cycle();
    chk("refresh_data1", 64'(bus.OutData1), BYP ? 64'h99 : 64'h10);
    chk("refresh_valid", 64'(bus.OutValid), 64'd1);
    drive(1'b1, 5'd0, 32'h33, 5'd0, 32'h34, 1'b1, 5'd0, 32'h44, 1'b1);
    cycle();
    chk("seamless_ready", 64'(ir_seen),      64'd1);
    chk("seamless_valid", 64'(bus.OutValid), 64'd1);
    chk("r0_data1",       64'(bus.OutData1), 64'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0);
    cycle();
    chk("r0_hold_data1", 64'(bus.OutData1), 64'd0);

    // Flush wins over a same-cycle accept.
    drive(1'b1, 5'd3, 32'h1, 5'd3, 32'h2, 1'b0, 5'd0, 32'd0, 1'b1);
    bus.Flush = 1'b1;
    cycle();
    chk("flush_valid", 64'(bus.OutValid), 64'd0);
    bus.Flush = 1'b0;

    // Reset in the middle of a load-use stall.
    set_ctl(5'd7, 1'b1, 1'b1);
    drive(1'b1, 5'd1, 32'd0, 5'd2, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle();
    set_ctl(5'd3, 1'b0, 1'b0);
    drive(1'b1, 5'd7, 32'h42, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_stall_ready", 64'(ir_seen),      64'd1);
    chk("reset_stall_data1", 64'(bus.OutData1), 64'h42);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom % 64) == 0;
      bus.Flush = ($urandom % 16) == 0;
      bus.InWriteReg = 5'($urandom % 8);
      bus.InRegWrite = 1'($urandom);
      bus.InMemRead  = ($urandom % 3) == 0;
      bus.InImm      = $urandom;
      bus.InALUOp    = 4'($urandom);
      drive(1'($urandom), 5'($urandom % 8), $urandom, 5'($urandom % 8), $urandom,
            1'($urandom), 5'($urandom % 8), $urandom, ($urandom % 4) != 0);
      cycle();
    end
    rst = 1'b0;
    bus.Flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
